// File: rtl/tis_pkg.sv
// Shared constants, header layout and FSM state type for the TIS config path.
// The node's program memory reuses PROG_DEPTH / INSTR_W from here.
package tis_pkg;

  localparam int PROG_DEPTH = 16;
  localparam int INSTR_W    = 16;
  localparam int ADDR_W     = $clog2(PROG_DEPTH);

  localparam logic [3:0] OP_LOAD = 4'hA;
  localparam logic [3:0] OP_RUN  = 4'h5;
  localparam logic [3:0] OP_HALT = 4'h3;

  localparam int HDR_OP_MSB   = 15;
  localparam int HDR_OP_LSB   = 12;
  localparam int HDR_NODE_MSB = 11;
  localparam int HDR_NODE_LSB = 8;
  localparam int HDR_CNT_MSB  = 7;
  localparam int HDR_CNT_LSB  = 4;
  localparam int HDR_ADDR_MSB = 3;
  localparam int HDR_ADDR_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0]        op;
    logic [3:0]        node;
    logic [3:0]        cnt_m1;
    logic [ADDR_W-1:0] addr;
  } hdr_t;

  function automatic hdr_t decode_hdr(input logic [INSTR_W-1:0] w);
    hdr_t h;
    h.op     = w[HDR_OP_MSB:HDR_OP_LSB];
    h.node   = w[HDR_NODE_MSB:HDR_NODE_LSB];
    h.cnt_m1 = w[HDR_CNT_MSB:HDR_CNT_LSB];
    h.addr   = w[HDR_ADDR_MSB:HDR_ADDR_LSB];
    return h;
  endfunction

endpackage

// File: rtl/tis_program_loader_if.sv
// Config stream in, instruction-write bus and run control out.
// slave = loader side, master = host/config side (also sees the node bus).
interface tis_program_loader_if #(
  parameter int NUM_NODES = 4
);
  import tis_pkg::*;

  logic [INSTR_W-1:0]   s_data;
  logic                 s_valid;
  logic                 s_ready;
  logic                 node_rst;
  logic [ADDR_W-1:0]    instr_addr;
  logic [INSTR_W-1:0]   instr_data;
  logic [NUM_NODES-1:0] write_instr;
  logic                 running;
  logic                 busy;
  logic                 error;

  modport slave (
    input  s_data, s_valid,
    output s_ready, node_rst, instr_addr, instr_data, write_instr,
           running, busy, error
  );

  modport master (
    output s_data, s_valid,
    input  s_ready, node_rst, instr_addr, instr_data, write_instr,
           running, busy, error
  );

endinterface

// File: rtl/tis_program_loader.sv
// Decodes framed LOAD/RUN/HALT commands into per-node program writes and
// the shared node run-reset. Every output is driven straight from a register.
module tis_program_loader
  import tis_pkg::*;
#(
  parameter int NUM_NODES = 4,
  parameter int RST_HOLD  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  tis_program_loader_if.slave   cfg
);

  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [NUM_NODES-1:0] ONE_HOT0 = 1;

  state_t               r_state;
  logic [3:0]           r_node;
  logic [3:0]           r_remain;
  logic [ADDR_W-1:0]    r_addr;
  logic                 r_discard;
  logic [HOLD_W-1:0]    r_hold_cnt;

  logic                 r_s_ready;
  logic                 r_node_rst;
  logic                 r_running;
  logic                 r_busy;
  logic                 r_error;
  logic [NUM_NODES-1:0] r_write;
  logic [ADDR_W-1:0]    r_instr_addr;
  logic [INSTR_W-1:0]   r_instr_data;

  logic                 w_accept;
  hdr_t                 w_hdr;
  logic                 w_node_ok;

  assign w_accept  = cfg.s_valid && r_s_ready;
  assign w_hdr     = decode_hdr(cfg.s_data);
  assign w_node_ok = ({1'b0, w_hdr.node} < 5'(NUM_NODES));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_node       <= '0;
      r_remain     <= '0;
      r_addr       <= '0;
      r_discard    <= 1'b0;
      r_hold_cnt   <= '0;
      r_s_ready    <= 1'b1;
      r_node_rst   <= 1'b1;
      r_running    <= 1'b0;
      r_busy       <= 1'b0;
      r_error      <= 1'b0;
      r_write      <= '0;
      r_instr_addr <= '0;
      r_instr_data <= '0;
    end else begin
      r_write <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            case (w_hdr.op)
              OP_LOAD: begin
                r_node    <= w_hdr.node;
                r_remain  <= w_hdr.cnt_m1;
                r_addr    <= w_hdr.addr;
                // Bad target or live nodes: still swallow the payload to stay framed.
                r_discard <= r_running || !w_node_ok;
                if (r_running || !w_node_ok)
                  r_error <= 1'b1;
                r_state   <= ST_LOAD;
                r_busy    <= 1'b1;
              end
              OP_RUN: begin
                r_node_rst <= 1'b0;
                r_running  <= 1'b1;
              end
              OP_HALT: begin
                r_node_rst <= 1'b1;
                r_running  <= 1'b0;
                r_hold_cnt <= HOLD_W'(RST_HOLD - 1);
                r_s_ready  <= 1'b0;
                r_busy     <= 1'b1;
                r_state    <= ST_HOLD;
              end
              default: r_error <= 1'b1;
            endcase
          end
        end

        ST_LOAD: begin
          if (w_accept) begin
            if (!r_discard) begin
              r_write      <= ONE_HOT0 << r_node;
              r_instr_addr <= r_addr;
              r_instr_data <= cfg.s_data;
            end
            r_addr   <= r_addr + 1'b1;
            r_remain <= r_remain - 1'b1;
            if (r_remain == '0) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end

        ST_HOLD: begin
          if (r_hold_cnt == '0) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_s_ready <= 1'b1;
          end else begin
            r_hold_cnt <= r_hold_cnt - 1'b1;
          end
        end

        default: begin
          r_state   <= ST_IDLE;
          r_busy    <= 1'b0;
          r_s_ready <= 1'b1;
        end
      endcase
    end
  end

  assign cfg.s_ready     = r_s_ready;
  assign cfg.node_rst    = r_node_rst;
  assign cfg.running     = r_running;
  assign cfg.busy        = r_busy;
  assign cfg.error       = r_error;
  assign cfg.write_instr = r_write;
  assign cfg.instr_addr  = r_instr_addr;
  assign cfg.instr_data  = r_instr_data;

endmodule

// File: doc/tis_program_loader.md
Name: tis_program_loader

Overview:
Configuration sequencer for a grid of TIS-style compute nodes. It accepts a framed stream of 16-bit words and decodes load/run/halt commands. Load commands become writes into the per-node 16-entry program memories over a shared instruction-write bus. Run and halt commands control the common run-reset to all nodes. It sits between the host/config interface and the node array.

Parameters:
NUM_NODES, 4, number of nodes driven; legal range 1..16.
RST_HOLD, 4, minimum cycles node_rst stays high after a HALT; must be >= 1.

Ports:
clk  input  1  clock; shared with all nodes.
rst  input  1  synchronous, active-high reset.
s_data  input  16  config stream word.
s_valid  input  1  s_data valid.
s_ready  output  1  loader accepts s_data this cycle.
node_rst  output  1  run-reset to all nodes; active high.
instr_addr  output  4  program memory address.
instr_data  output  16  instruction word.
write_instr  output  NUM_NODES  one-hot write strobe per node.
running  output  1  nodes released from reset.
busy  output  1  frame in progress (state LOAD or HOLD).
error  output  1  sticky protocol error flag.

Behaviour:
- A word is accepted when s_valid && s_ready. All outputs are registered.
- Header word fields:
  - [15:12] opcode: 4'hA LOAD, 4'h5 RUN, 4'h3 HALT; any other value is illegal.
  - [11:8] node index.
  - [7:4] count-1 (payload of 1..16 words).
  - [3:0] start address.
- States:
  - IDLE: waiting for a header. s_ready=1.
  - LOAD: consuming payload words. s_ready=1.
  - HOLD: reset hold after HALT. s_ready=0.
- Reset values: state=IDLE, node_rst=1, running=0, busy=0, error=0, write_instr=0, instr_addr=0, instr_data=0.
- IDLE, LOAD header:
  - Latch node index, remaining=count, addr=start; go to LOAD.
  - If running=1, or node index >= NUM_NODES: set error, go to LOAD in discard mode. Payload words are consumed, no strobes.
- LOAD, each accepted payload word (non-discard):
  - Next cycle: write_instr[node]=1 for exactly one cycle, instr_addr=addr, instr_data=word. Latency is 1 cycle from acceptance.
  - addr increments modulo 16, so start 14 with count 4 writes 14,15,0,1.
  - When the last payload word is accepted, return to IDLE the same cycle. A back-to-back header on the next cycle is accepted.
- IDLE, RUN:
  - Next cycle node_rst=0, running=1.
  - RUN while already running: no-op, no error.
- IDLE, HALT:
  - Next cycle node_rst=1, running=0. Go to HOLD for RST_HOLD cycles, then IDLE.
  - HALT while not running still performs the hold.
- IDLE, illegal opcode: set error, word discarded, remain IDLE.
- write_instr is zero whenever not writing. Never more than one bit is set.
- error clears only on rst.
- busy=1 in LOAD and HOLD.
- rst mid-frame: frame is abandoned, no further strobes. Outputs go to reset values the next cycle, and node_rst=1 immediately after the reset edge.
- s_valid low inside LOAD: the loader waits indefinitely. There is no timeout, and addr and remaining are held.

Decomposition:
- Shared package tis_pkg holds:
  - opcode constants (OP_LOAD=4'hA, OP_RUN=4'h5, OP_HALT=4'h3);
  - header field bit positions;
  - the state enum;
  - PROG_DEPTH=16 and INSTR_W=16, reused by the node.
- No sub-module is needed. The decoder and FSM stay in one block; the header decode is a package function.

Test Plan:
- Load one word: after rst, send A1_02 then 1234 (NUM_NODES=4), header 16'hA102 → one cycle later write_instr=4'b0010, instr_addr=2, instr_data=16'h1234. node_rst stays 1.
- Address wrap: header 16'hA03E followed by D0..D3 → writes to node 0 at addr 14,15,0,1 on four consecutive cycles, no gaps. busy drops after the last word.
- Run then halt: send 16'h5000 → node_rst=0 and running=1 one cycle later. Then send 16'h3000 → node_rst=1, s_ready=0 for exactly RST_HOLD=4 cycles, then s_ready=1.
- Errors:
  - 16'hA500 (node 5 >= 4) plus 1 payload word → no strobe, error=1, next header decoded normally.
  - 16'h7000 → error=1, remain IDLE.
  - LOAD while running → payload consumed, no strobe, error=1.
- Reset mid-frame: header 16'hA0F0, 3 payload words, assert rst 1 cycle → outputs at reset values. A subsequent 16'hA100 plus 1 word writes node 1 addr 0 normally.
- Stall: deassert s_valid for 5 cycles mid-payload → no strobes during the gap. Writes resume at the next consecutive address.
